// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction fields in, datapath controls out, between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] state_o;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, state_o
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM-subset controller: Moore sequencer, ALU decode, NZCV flags, condition-gated writes.
// LDR 5 / STR 4 / DP 4 / B 3 / undefined 2 cycles; no backpressure, one instruction at a time.
module multicycle_ctrl_fsm (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, next;
  logic [3:0] flags;
  logic       cond_q;

  logic       next_pc, reg_w, mem_w, branch, alu_op, ir_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, alu_ctl, flag_w;
  logic       no_write, pcs;

  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = cy;
      4'b0011: cond_ex = ~cy;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = cy & ~z;
      4'b1001: cond_ex = ~cy | z;
      4'b1010: cond_ex = ~(n ^ v);
      4'b1011: cond_ex = n ^ v;
      4'b1100: cond_ex = ~z & ~(n ^ v);
      4'b1101: cond_ex = z | (n ^ v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      flags  <= 4'b0000;
      cond_q <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE)
        cond_q <= cond_ex(bus.Cond, flags);
      // flag_w is only non-zero while alu_op is set, i.e. in EXECR/EXECI
      if (flag_w[1] & cond_q)
        flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0] & cond_q)
        flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_comb begin
    next       = state;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        next       = DECODE;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (bus.Op)
          2'b01:   next = MEMADR;
          2'b00:   next = bus.Funct[5] ? EXECI : EXECR;
          2'b10:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        next      = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        next    = FETCH;
      end
      EXECR: begin
        alu_op = 1'b1;
        next   = ALUWB;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        next  = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        next       = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  always_comb begin
    alu_ctl = 2'b00;
    flag_w  = 2'b00;
    if (alu_op) begin
      case (bus.Funct[4:1])
        4'b0010, 4'b1010: alu_ctl = 2'b01;
        4'b0000:          alu_ctl = 2'b10;
        4'b1100:          alu_ctl = 2'b11;
        default:          alu_ctl = 2'b00;
      endcase
      flag_w[1] = bus.Funct[0];
      flag_w[0] = bus.Funct[0] & ~alu_ctl[1];
    end
  end

  // CMP suppression is taken from the held instruction, since ALUWB itself runs with ALUOp=0
  assign no_write = (bus.Op == 2'b00) & (bus.Funct[4:1] == 4'b1010);
  assign pcs      = ((bus.Rd == 4'd15) & reg_w) | branch;

  assign bus.PCWrite    = ~reset & (next_pc | (pcs & cond_q));
  assign bus.RegWrite   = ~reset & reg_w & cond_q & ~no_write;
  assign bus.MemWrite   = ~reset & mem_w & cond_q;
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.ALUControl = alu_ctl;
  assign bus.state_o    = state;

endmodule
